// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer and control decoder with a parametrised SRAM wait count.
// Optional PAUSE instruction (opcode 1101) is built only when ISDU_PAUSE_EN is defined.
module lc3_ctrl_fsm #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Halted
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH_MAR, S_FETCH_RD, S_FETCH_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR_EVAL, S_BR_TAKE, S_JMP, S_JSR_SAVE, S_JSR_PC,
    S_LEA, S_LD_ADDR, S_LDR_ADDR, S_ST_ADDR, S_STR_ADDR,
    S_RD, S_LD_WB, S_ST_MDR, S_WR
`ifdef ISDU_PAUSE_EN
    , S_PAUSE1, S_PAUSE2
`endif
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             run_d;
  logic             mem_state;
  logic             wait_last;

  // One shared counter times every SRAM access; it idles at zero outside memory states.
  assign mem_state = (state == S_FETCH_RD) || (state == S_RD) || (state == S_WR);
  assign wait_last = (wait_cnt == CNT_W'(MEM_WAIT - 1));

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

`ifdef ISDU_PAUSE_EN
  logic pause_seen;
`else
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_HALTED;
      wait_cnt <= '0;
      run_d    <= 1'b0;
    end else begin
      state    <= next_state;
      run_d    <= Run;
      wait_cnt <= (mem_state && !wait_last) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

`ifdef ISDU_PAUSE_EN
  always_ff @(posedge Clk) begin
    if (Reset) pause_seen <= 1'b0;
    else       pause_seen <= (state == S_PAUSE1);
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX  = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
    Mem_OE = 1'b1; Mem_WE = 1'b1; Halted = 1'b0;

    case (state)
      S_HALTED: begin
        Halted = 1'b1;
        if (Run && !run_d) next_state = S_FETCH_MAR;
      end
      S_FETCH_MAR: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1;
        next_state = S_FETCH_RD;
      end
      S_FETCH_RD: begin
        Mem_OE = 1'b0;
        LD_MDR = wait_last;
        if (wait_last) next_state = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: next_state = S_ADD;
          4'b0101: next_state = S_AND;
          4'b1001: next_state = S_NOT;
          4'b0000: next_state = S_BR_EVAL;
          4'b1100: next_state = S_JMP;
          4'b0100: next_state = S_JSR_SAVE;
          4'b1110: next_state = S_LEA;
          4'b0010: next_state = S_LD_ADDR;
          4'b0110: next_state = S_LDR_ADDR;
          4'b0011: next_state = S_ST_ADDR;
          4'b0111: next_state = S_STR_ADDR;
          4'b1111: next_state = S_HALTED;
`ifdef ISDU_PAUSE_EN
          4'b1101: next_state = S_PAUSE1;
`endif
          default: next_state = S_FETCH_MAR;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR2MUX = (state != S_NOT) && IR_5;
        ALUK   = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
        next_state = S_FETCH_MAR;
      end
      S_BR_EVAL: next_state = BEN ? S_BR_TAKE : S_FETCH_MAR;
      S_BR_TAKE: begin
        PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10; LD_PC = 1'b1;
        next_state = S_FETCH_MAR;
      end
      S_JMP: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
        next_state = S_FETCH_MAR;
      end
      S_JSR_SAVE: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
        next_state = S_JSR_PC;
      end
      S_JSR_PC: begin
        PCMUX = 2'b01; LD_PC = 1'b1;
        if (IR_11) begin
          ADDR1MUX = 1'b1; ADDR2MUX = 2'b11;
        end else begin
          SR1MUX = 1'b1; ADDR1MUX = 1'b0; ADDR2MUX = 2'b00;
        end
        next_state = S_FETCH_MAR;
      end
      S_LEA: begin
        GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_FETCH_MAR;
      end
      S_LD_ADDR, S_ST_ADDR: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10;
        next_state = (state == S_LD_ADDR) ? S_RD : S_ST_MDR;
      end
      S_LDR_ADDR, S_STR_ADDR: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; SR1MUX = 1'b1; ADDR2MUX = 2'b01;
        next_state = (state == S_LDR_ADDR) ? S_RD : S_ST_MDR;
      end
      S_RD: begin
        Mem_OE = 1'b0;
        LD_MDR = wait_last;
        if (wait_last) next_state = S_LD_WB;
      end
      S_LD_WB: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = S_FETCH_MAR;
      end
      S_ST_MDR: begin
        SR1MUX = 1'b0; ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
        next_state = S_WR;
      end
      S_WR: begin
        Mem_WE = 1'b0;
        if (wait_last) next_state = S_FETCH_MAR;
      end
`ifdef ISDU_PAUSE_EN
      S_PAUSE1: begin
        LD_LED = !pause_seen;
        if (Continue) next_state = S_PAUSE2;
      end
      S_PAUSE2: if (!Continue) next_state = S_FETCH_MAR;
`endif
      default: next_state = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Self-checking bench for lc3_ctrl_fsm: two instances (MEM_WAIT 2 and 4) compared cycle by
// cycle against a per-instruction list of expected control words built from the instruction rules.
module tb_lc3_ctrl_fsm;

  localparam int MW0 = 2;
  localparam int MW1 = 4;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, halted;
  } ctrl_t;

  typedef struct packed {
    logic       reset, run, cont;
    logic [3:0] op;
    logic       ir5, ir11, ben;
  } in_t;

  logic       clk = 1'b0;
  in_t        inp [2];
  wire ctrl_t obs [2];
  int         mw  [2] = '{MW0, MW1};

  ctrl_t exp_q [$];
  ctrl_t hist  [$];
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lc3_ctrl_fsm #(.MEM_WAIT(g == 0 ? MW0 : MW1)) dut (
      .Clk(clk), .Reset(inp[g].reset), .Run(inp[g].run), .Continue(inp[g].cont),
      .Opcode(inp[g].op), .IR_5(inp[g].ir5), .IR_11(inp[g].ir11), .BEN(inp[g].ben),
      .LD_MAR(obs[g].ld_mar), .LD_MDR(obs[g].ld_mdr), .LD_IR(obs[g].ld_ir),
      .LD_BEN(obs[g].ld_ben), .LD_CC(obs[g].ld_cc), .LD_REG(obs[g].ld_reg),
      .LD_PC(obs[g].ld_pc), .LD_LED(obs[g].ld_led),
      .GatePC(obs[g].gate_pc), .GateMDR(obs[g].gate_mdr), .GateALU(obs[g].gate_alu),
      .GateMARMUX(obs[g].gate_marmux), .PCMUX(obs[g].pcmux), .DRMUX(obs[g].drmux),
      .SR1MUX(obs[g].sr1mux), .SR2MUX(obs[g].sr2mux), .ADDR1MUX(obs[g].addr1mux),
      .ADDR2MUX(obs[g].addr2mux), .ALUK(obs[g].aluk),
      .Mem_CE(obs[g].mem_ce), .Mem_UB(obs[g].mem_ub), .Mem_LB(obs[g].mem_lb),
      .Mem_OE(obs[g].mem_oe), .Mem_WE(obs[g].mem_we), .Halted(obs[g].halted)
    );
  end

  // ---------------- reference model: control words per instruction ----------------
  function automatic ctrl_t idle_v();
    ctrl_t c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t halt_v();
    ctrl_t c = idle_v();
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic void push_mem(int m, bit rd);
    for (int k = 0; k < m; k++) begin
      ctrl_t c = idle_v();
      if (rd) begin
        c.mem_oe = 1'b0;
        c.ld_mdr = (k == m - 1);
      end else begin
        c.mem_we = 1'b0;
      end
      exp_q.push_back(c);
    end
  endfunction

  function automatic void push_instr(int m, logic [3:0] op, logic ir5, logic ir11, logic ben);
    ctrl_t c;
    c = idle_v(); c.gate_pc = 1; c.ld_mar = 1; c.pcmux = 2'b10; c.ld_pc = 1; exp_q.push_back(c);
    push_mem(m, 1'b1);
    c = idle_v(); c.gate_mdr = 1; c.ld_ir = 1; exp_q.push_back(c);
    c = idle_v(); c.ld_ben = 1; exp_q.push_back(c);
    case (op)
      4'h1, 4'h5, 4'h9: begin
        c = idle_v(); c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk   = (op == 4'h1) ? 2'b00 : (op == 4'h5) ? 2'b01 : 2'b10;
        c.sr2mux = (op != 4'h9) && ir5;
        exp_q.push_back(c);
      end
      4'h0: begin
        exp_q.push_back(idle_v());
        if (ben) begin
          c = idle_v(); c.pcmux = 2'b01; c.addr1mux = 1; c.addr2mux = 2'b10; c.ld_pc = 1;
          exp_q.push_back(c);
        end
      end
      4'hC: begin
        c = idle_v(); c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_pc = 1;
        exp_q.push_back(c);
      end
      4'h4: begin
        c = idle_v(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; exp_q.push_back(c);
        c = idle_v(); c.pcmux = 2'b01; c.ld_pc = 1;
        if (ir11) begin c.addr1mux = 1; c.addr2mux = 2'b11; end
        else      begin c.sr1mux = 1; end
        exp_q.push_back(c);
      end
      4'hE: begin
        c = idle_v(); c.gate_marmux = 1; c.addr1mux = 1; c.addr2mux = 2'b10;
        c.ld_reg = 1; c.ld_cc = 1;
        exp_q.push_back(c);
      end
      4'h2, 4'h3, 4'h6, 4'h7: begin
        c = idle_v(); c.gate_marmux = 1; c.ld_mar = 1;
        if (op == 4'h6 || op == 4'h7) begin c.sr1mux = 1; c.addr2mux = 2'b01; end
        else begin c.addr1mux = 1; c.addr2mux = 2'b10; end
        exp_q.push_back(c);
        if (op == 4'h2 || op == 4'h6) begin
          push_mem(m, 1'b1);
          c = idle_v(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; exp_q.push_back(c);
        end else begin
          c = idle_v(); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; exp_q.push_back(c);
          push_mem(m, 1'b0);
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- scenario drivers ----------------
  task automatic start(int d);
    inp[d].reset = 1'b1;
    inp[d].run   = 1'b0;
    @(negedge clk);
    inp[d].reset = 1'b0;
    inp[d].run   = 1'b1;
  endtask

  // Plays one instruction from its FETCH_MAR cycle; abort_at >= 0 stops after that cycle.
  task automatic exec_instr(int d, logic [3:0] op, logic ir5, logic ir11, logic ben,
                            int abort_at, string name);
    ctrl_t o;
    exp_q.delete();
    hist.delete();
    push_instr(mw[d], op, ir5, ir11, ben);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = obs[d];
      hist.push_back(o);
      checks++;
      if (o !== exp_q[i])
        $display("FAIL %s dut%0d op=%h cyc %0d: got %h, expected %h", name, d, op, i, o, exp_q[i]);
      else
        passes++;
      if (i == 0) begin
        inp[d].op = op; inp[d].ir5 = ir5; inp[d].ir11 = ir11; inp[d].ben = ben;
      end
      if (i == abort_at) break;
    end
  endtask

  task automatic test_reset(int d);
    inp[d].reset = 1'b1;
    inp[d].run   = 1'b0;
    @(negedge clk);
    checks++;
    if (obs[d] !== halt_v()) $display("FAIL reset_state dut%0d: got %h, expected %h", d, obs[d], halt_v());
    else passes++;
    inp[d].reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs[d] !== halt_v()) $display("FAIL reset_idle dut%0d: got %h, expected %h", d, obs[d], halt_v());
    else passes++;
  endtask

  task automatic test_fetch();
    int n_oe = 0;
    start(0);
    exec_instr(0, 4'h1, 1'b1, 1'b0, 1'b0, -1, "fetch_add");
    foreach (hist[i]) if (hist[i].mem_oe === 1'b0) n_oe++;
    checks++;
    if (n_oe !== MW0) $display("FAIL fetch_oe_cycles: got %0d, expected %0d", n_oe, MW0);
    else passes++;
    checks++;
    if ({hist[1].ld_mdr, hist[2].ld_mdr, hist[3].ld_ir} !== 3'b011)
      $display("FAIL fetch_mdr_ir: got %b, expected 011", {hist[1].ld_mdr, hist[2].ld_mdr, hist[3].ld_ir});
    else passes++;
  endtask

  task automatic test_ldr();
    int run_len = 0, best = 0, n_wb = 0;
    start(1);
    exec_instr(1, 4'h6, 1'b0, 1'b0, 1'b0, -1, "ldr");
    for (int i = MW1 + 3; i < hist.size(); i++) begin
      run_len = (hist[i].mem_oe === 1'b0) ? run_len + 1 : 0;
      if (run_len > best) best = run_len;
      if (hist[i].ld_reg && hist[i].ld_cc && hist[i].gate_mdr) n_wb++;
    end
    checks++;
    if (best !== MW1) $display("FAIL ldr_oe_run: got %0d, expected %0d", best, MW1);
    else passes++;
    checks++;
    if (n_wb !== 1) $display("FAIL ldr_writeback: got %0d, expected 1", n_wb);
    else passes++;
    exec_instr(1, 4'h1, 1'b0, 1'b0, 1'b0, -1, "ldr_next");
  endtask

  task automatic test_branch();
    int n_pc;
    start(0);
    exec_instr(0, 4'h0, 1'b0, 1'b0, 1'b1, -1, "br_taken");
    n_pc = 0;
    foreach (hist[i]) if (hist[i].ld_pc === 1'b1) n_pc++;
    checks++;
    if (n_pc !== 2) $display("FAIL br_taken_ldpc: got %0d, expected 2", n_pc);
    else passes++;
    exec_instr(0, 4'h0, 1'b0, 1'b0, 1'b0, -1, "br_not_taken");
    n_pc = 0;
    foreach (hist[i]) if (hist[i].ld_pc === 1'b1) n_pc++;
    checks++;
    if (n_pc !== 1) $display("FAIL br_not_taken_ldpc: got %0d, expected 1", n_pc);
    else passes++;
    exec_instr(0, 4'h5, 1'b0, 1'b0, 1'b0, -1, "br_next");
  endtask

  task automatic test_jsr();
    start(0);
    exec_instr(0, 4'h4, 1'b0, 1'b0, 1'b0, -1, "jsrr");
    checks++;
    if ({hist[6].addr1mux, hist[6].addr2mux, hist[5].drmux, hist[5].ld_reg} !== 5'b00011)
      $display("FAIL jsrr_mux: got %b, expected 00011",
               {hist[6].addr1mux, hist[6].addr2mux, hist[5].drmux, hist[5].ld_reg});
    else passes++;
    exec_instr(0, 4'h4, 1'b0, 1'b1, 1'b0, -1, "jsr");
    checks++;
    if ({hist[6].addr1mux, hist[6].addr2mux} !== 3'b111)
      $display("FAIL jsr_mux: got %b, expected 111", {hist[6].addr1mux, hist[6].addr2mux});
    else passes++;
  endtask

  task automatic test_trap();
    start(0);
    exec_instr(0, 4'hF, 1'b0, 1'b0, 1'b0, -1, "trap");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs[0] !== halt_v()) $display("FAIL trap_hold cyc %0d: got %h, expected %h", i, obs[0], halt_v());
      else passes++;
    end
    inp[0].run = 1'b0;
    @(negedge clk);
    checks++;
    if (obs[0] !== halt_v()) $display("FAIL trap_run_low: got %h, expected %h", obs[0], halt_v());
    else passes++;
    inp[0].run = 1'b1;
    exec_instr(0, 4'h9, 1'b0, 1'b0, 1'b0, -1, "trap_restart");
  endtask

  task automatic test_reset_mid(int d, logic [3:0] op, int abort_at, string name);
    start(d);
    exec_instr(d, op, 1'b0, 1'b0, 1'b0, abort_at, name);
    inp[d].reset = 1'b1;
    inp[d].run   = 1'b0;
    @(negedge clk);
    checks++;
    if (obs[d] !== halt_v()) $display("FAIL %s_abort: got %h, expected %h", name, obs[d], halt_v());
    else passes++;
    inp[d].reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs[d] !== halt_v()) $display("FAIL %s_after: got %h, expected %h", name, obs[d], halt_v());
    else passes++;
    inp[d].run = 1'b1;
    exec_instr(d, 4'h1, 1'b1, 1'b0, 1'b0, -1, name);
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      start(d);
      for (int n = 0; n < 40; n++)
        exec_instr(d, 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'($urandom),
                   -1, "random");
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) inp[d] = '0;
    test_reset(0);
    test_reset(1);
    test_fetch();
    test_ldr();
    test_branch();
    test_jsr();
    test_trap();
    test_reset_mid(0, 4'h3, MW0 + 5, "st_reset");
    test_reset_mid(1, 4'h6, MW1 + 4, "ldr_reset");
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_fsm.md
# lc3_ctrl_fsm

Parametrised LC-3 instruction sequencer and control decoder, the next-generation control unit of the SLC-3 datapath. Fetches, decodes and sequences ADD/AND/NOT/BR/JMP/JSR/JSRR/LD/LDR/LEA/ST/STR/TRAP. SRAM wait-state count is a parameter; every memory access counts through a shared wait counter. Drives register loads, bus gates, mux selects and SRAM strobes for the whole datapath.

## Interface
- MEM_WAIT, 2: SRAM cycles per access, ≥1; strobe held low this many cycles
- CNT_W, $clog2(MEM_WAIT+1): wait-counter width (derived, do not override)
- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- Run  in  1  start; rising edge leaves HALTED
- Continue  in  1  PAUSE handshake (ISDU_PAUSE_EN only)
- Opcode  in  4  IR[15:12]
- IR_5, IR_11  in  1 each  immediate select / JSR vs JSRR
- BEN  in  1  registered branch-enable from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, one-hot or none
- PCMUX  out  2  00 bus, 01 address adder, 10 PC+1
- DRMUX  out  1  0 IR[11:9], 1 R7
- SR1MUX  out  1  0 IR[11:9], 1 IR[8:6]
- SR2MUX  out  1  0 register, 1 imm5
- ADDR1MUX  out  1  0 SR1, 1 PC
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
- Halted  out  1  high in HALTED

## Operation
- Moore decode: outputs are functions of state (plus IR_5 for SR2MUX). Defaults: all LD_*/Gate* 0, muxes 0, Mem_OE=Mem_WE=1. Mem_CE/UB/LB tied 0.
- HALTED: Halted=1. Exit to FETCH_MAR on Run=1 with Run_d=0 (Run_d = Run registered).
- FETCH_MAR: GatePC, LD_MAR, PCMUX=10, LD_PC → FETCH_RD.
- Memory states FETCH_RD, RD, WR: Mem_OE (reads) or Mem_WE (writes) = 0 every cycle; counter runs 0..MEM_WAIT-1, LD_MDR=1 on read when counter = MEM_WAIT-1; exit after that cycle; counter cleared on exit.
- FETCH_RD → FETCH_IR (GateMDR, LD_IR) → DECODE (LD_BEN).
- DECODE by Opcode: 0001 ADD, 0101 AND, 1001 NOT (SR1MUX=1, GateALU, LD_REG, LD_CC; ADD/AND SR2MUX=IR_5) → FETCH_MAR.
- 0000 BR_EVAL: BEN=1 → BR_TAKE (PCMUX=01, ADDR1MUX=1, ADDR2MUX=10, LD_PC), else FETCH_MAR.
- 1100 JMP: SR1MUX=1, ALUK=11, GateALU, LD_PC, PCMUX=00.
- 0100 JSR_SAVE: GatePC, DRMUX=1, LD_REG → JSR_PC: IR_11=1 PC←PC+off11 (ADDR1MUX=1, ADDR2MUX=11); IR_11=0 PC←BaseR (SR1MUX=1, ADDR1MUX=0, ADDR2MUX=00); PCMUX=01, LD_PC. Both sampled in JSR_PC.
- 1110 LEA: GateMARMUX, ADDR1MUX=1, ADDR2MUX=10, LD_REG, LD_CC.
- 0010 LD / 0110 LDR: address state (GateMARMUX, LD_MAR; PC+off9 / SR1MUX=1 base+off6) → RD → LD_WB (GateMDR, LD_REG, LD_CC).
- 0011 ST / 0111 STR: address state → ST_MDR (SR1MUX=0, ALUK=11, GateALU, LD_MDR) → WR.
- 1111 TRAP → HALTED.
- All other opcodes (incl. 1101 without macro) → FETCH_MAR, no side effect.

## Timing
- Reset: next edge State=HALTED, counter=0, Run_d=0; all outputs at defaults, Halted=1.
- Reset mid-access: strobes deassert the cycle after the reset edge; no partial LD_MDR.
- Fetch = MEM_WAIT+3 cycles (MAR, RD×MEM_WAIT, IR, DECODE). ALU/JMP/LEA/BR-not-taken = fetch+1; BR-taken, JSR = fetch+2; LD/LDR = fetch+MEM_WAIT+2; ST/STR = fetch+MEM_WAIT+2.
- Run held high across TRAP does not restart; a fresh 0→1 is required.
- BEN sampled in BR_EVAL, one cycle after LD_BEN.

## Configuration
- ISDU_PAUSE_EN defined: opcode 1101 → PAUSE1 (LD_LED=1 on entry cycle) waits Continue=1 → PAUSE2 waits Continue=0 → FETCH_MAR.
- Undefined: PAUSE states absent, LD_LED constant 0, Continue ignored, 1101 treated as unknown opcode.

## Test plan
- Reset, MEM_WAIT=2, Run 0→1: FETCH_MAR 1 cycle later, Mem_OE low exactly 2 cycles, LD_MDR on 2nd, LD_IR next cycle.
- MEM_WAIT=4, Opcode 0110: Mem_OE low 4 consecutive cycles in RD; LD_REG+LD_CC+GateMDR one cycle; instruction total 13 cycles.
- Opcode 0000, BEN=1 then BEN=0: BR_TAKE asserts LD_PC with PCMUX=01, ADDR2MUX=10; not-taken returns to FETCH_MAR with no LD_PC.
- Opcode 0100, IR_11=0 and 1: JSR_SAVE DRMUX=1 LD_REG; JSR_PC ADDR1MUX=0/ADDR2MUX=00 vs ADDR1MUX=1/ADDR2MUX=11.
- Opcode 1111 with Run held 1: HALTED and stays; Run 0→1 restarts fetch.
- Reset asserted during WR cycle 1: Mem_WE=1 next cycle, Halted=1; with ISDU_PAUSE_EN, 1101 pulses LD_LED and waits on Continue 1 then 0.
